// File: rtl/mem_responder.sv
// mem_responder: word-addressed RAM answering RD/WT requests after LATENCY cycles.
// Define MEM_RANGE_CHECK_EN to add memErr and drop out-of-range accesses.
`ifndef IOSTATEWIDTH
`define IOSTATEWIDTH 2
`endif
`ifndef IDEL
`define IDEL 2'b00
`endif
`ifndef RD
`define RD 2'b01
`endif
`ifndef WT
`define WT 2'b10
`endif
`ifndef ADDRWIDTH
`define ADDRWIDTH 16
`endif
`ifndef WORDWIDTH
`define WORDWIDTH 16
`endif

module mem_responder #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 256,
  parameter int IDX_W   = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [`IOSTATEWIDTH-1:0] rwToMem,
  input  logic [`ADDRWIDTH-1:0]    addrToMem,
  input  logic [`WORDWIDTH-1:0]    dataToMem,
  output logic                     rdEn,
  output logic                     wtEn,
  output logic [`WORDWIDTH-1:0]    dataFromMem
`ifdef MEM_RANGE_CHECK_EN
  ,
  output logic                     memErr
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RELEASE
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(LATENCY - 1);

  state_t state, state_nxt;

  logic [7:0]            cnt;
  logic                  op_rd;
  logic [IDX_W-1:0]      idx;
  logic [`WORDWIDTH-1:0] wdata;
  logic                  oob;
  logic [`WORDWIDTH-1:0] ram [DEPTH];

  logic is_req;
  logic is_idel;
  logic req_oob;
  logic accept;
  logic done;
  logic ram_we;

  assign is_req  = (rwToMem == `RD) || (rwToMem == `WT);
  assign is_idel = (rwToMem == `IDEL);

`ifdef MEM_RANGE_CHECK_EN
  assign req_oob = |addrToMem[`ADDRWIDTH-1:IDX_W];
`else
  // High address bits alias onto the RAM index.
  logic unused_hi;
  assign unused_hi = ^addrToMem[`ADDRWIDTH-1:IDX_W];
  assign req_oob   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (is_req) state_nxt = BUSY;
      BUSY: begin
        if (is_idel)           state_nxt = IDLE;
        else if (cnt == 8'd0)  state_nxt = RELEASE;
      end
      RELEASE: if (is_idel) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    accept = 1'b0;
    done   = 1'b0;
    unique case (state)
      IDLE:    accept = is_req;
      BUSY:    done   = !is_idel && (cnt == 8'd0);
      default: ;
    endcase
  end

  assign ram_we = done && !op_rd && !oob && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= 8'd0;
      op_rd       <= 1'b0;
      idx         <= '0;
      wdata       <= '0;
      oob         <= 1'b0;
      rdEn        <= 1'b0;
      wtEn        <= 1'b0;
      dataFromMem <= '0;
    end else begin
      rdEn <= done && op_rd;
      wtEn <= done && !op_rd;
      if (accept) begin
        op_rd <= (rwToMem == `RD);
        idx   <= addrToMem[IDX_W-1:0];
        wdata <= dataToMem;
        oob   <= req_oob;
        cnt   <= CNT_INIT;
      end else if (state == BUSY && !is_idel && cnt != 8'd0) begin
        cnt <= cnt - 8'd1;
      end
      if (done && op_rd)
        dataFromMem <= oob ? '0 : ram[idx];
    end
  end

`ifdef MEM_RANGE_CHECK_EN
  always_ff @(posedge clk) begin
    if (reset) memErr <= 1'b0;
    else       memErr <= done && oob;
  end
`endif

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram[idx] <= wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: directed table plus hand sequences for mem_responder.
// Covers latency, abort, reset mid-op, hold-after-pulse and range/alias.
module tb_mem_responder;

  localparam int LAT = 4;
  localparam logic [1:0] IDEL = 2'b00;
  localparam logic [1:0] RD   = 2'b01;
  localparam logic [1:0] WT   = 2'b10;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  rwToMem;
  logic [15:0] addrToMem;
  logic [15:0] dataToMem;
  logic        rdEn;
  logic        wtEn;
  logic [15:0] dataFromMem;
  logic        err_s;
`ifdef MEM_RANGE_CHECK_EN
  logic        memErr;
  assign err_s = memErr;
`else
  assign err_s = 1'b0;
`endif

  mem_responder #(.LATENCY(LAT), .DEPTH(256), .IDX_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .rwToMem(rwToMem),
    .addrToMem(addrToMem),
    .dataToMem(dataToMem),
    .rdEn(rdEn),
    .wtEn(wtEn),
    .dataFromMem(dataFromMem)
`ifdef MEM_RANGE_CHECK_EN
    ,
    .memErr(memErr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp;
  } vec_t;

  vec_t        tbl [12];
  int          n_vec = 0;
  int          n_err = 0;
  logic [15:0] last_rd = 16'h0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Starts and ends #1 after a rising edge.
  task automatic run_req(input logic [1:0] op, input logic [15:0] addr,
                         input logic [15:0] data, input logic [15:0] exp,
                         input logic exp_err, input int extra,
                         input string name);
    int   pulse_at;
    int   extra_p;
    logic got_rd, got_wt, got_err;
    logic [15:0] got_data;
    pulse_at  = 0;
    extra_p   = 0;
    got_rd    = 1'b0;
    got_wt    = 1'b0;
    got_err   = 1'b0;
    got_data  = 16'h0;
    rwToMem   = op;
    addrToMem = addr;
    dataToMem = data;
    @(posedge clk);
    #1;
    addrToMem = ~addr;
    dataToMem = ~data;
    for (int e = 1; e <= LAT + 4 && pulse_at == 0; e++) begin
      @(posedge clk);
      #1;
      if (rdEn || wtEn) begin
        pulse_at = e;
        got_rd   = rdEn;
        got_wt   = wtEn;
        got_data = dataFromMem;
        got_err  = err_s;
      end
    end
    check({name, ".lat"}, pulse_at, LAT);
    check({name, ".kind"}, {got_rd, got_wt},
          (op == RD) ? 2'b10 : 2'b01);
    check({name, ".err"}, got_err, exp_err);
    if (op == RD) begin
      check({name, ".data"}, got_data, exp);
      last_rd = exp;
    end
    for (int k = 0; k < extra; k++) begin
      @(posedge clk);
      #1;
      if (rdEn || wtEn) extra_p++;
    end
    rwToMem = IDEL;
    @(posedge clk);
    #1;
    if (rdEn || wtEn) extra_p++;
    check({name, ".once"}, extra_p, 0);
    check({name, ".hold"}, dataFromMem, last_rd);
  endtask

  initial begin
    int pulses;
    tbl[0]  = '{WT, 16'h0005, 16'hBEEF, 16'h0};
    tbl[1]  = '{RD, 16'h0005, 16'h0,    16'hBEEF};
    tbl[2]  = '{WT, 16'h0007, 16'h7777, 16'h0};
    tbl[3]  = '{WT, 16'h0010, 16'h1234, 16'h0};
    tbl[4]  = '{WT, 16'h0011, 16'h5678, 16'h0};
    tbl[5]  = '{RD, 16'h0010, 16'h0,    16'h1234};
    tbl[6]  = '{RD, 16'h0011, 16'h0,    16'h5678};
    tbl[7]  = '{WT, 16'h0010, 16'h0000, 16'h0};
    tbl[8]  = '{RD, 16'h0010, 16'h0,    16'h0000};
    tbl[9]  = '{RD, 16'h0005, 16'h0,    16'hBEEF};
    tbl[10] = '{WT, 16'h0009, 16'h5555, 16'h0};
    tbl[11] = '{RD, 16'h0007, 16'h0,    16'h7777};

    reset     = 1'b1;
    rwToMem   = IDEL;
    addrToMem = 16'h0;
    dataToMem = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.rdEn", rdEn, 1'b0);
    check("rst.wtEn", wtEn, 1'b0);
    check("rst.data", dataFromMem, 16'h0);
    check("rst.err", err_s, 1'b0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++)
      run_req(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].exp, 1'b0, 0,
              $sformatf("vec%0d", i));

    // Requester gives up two cycles into a write.
    rwToMem   = WT;
    addrToMem = 16'h0007;
    dataToMem = 16'h1234;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    rwToMem = IDEL;
    pulses  = 0;
    repeat (LAT + 2) begin
      @(posedge clk);
      #1;
      if (rdEn || wtEn) pulses++;
    end
    check("abort.pulse", pulses, 0);
    run_req(RD, 16'h0007, 16'h0, 16'h7777, 1'b0, 0, "abort.rd");

    run_req(RD, 16'h0005, 16'h0, 16'hBEEF, 1'b0, 3, "holdrd");
    run_req(RD, 16'h0005, 16'h0, 16'hBEEF, 1'b0, 0, "rerd");

    // Reset lands in the middle of a pending write.
    rwToMem   = WT;
    addrToMem = 16'h0009;
    dataToMem = 16'hAAAA;
    @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rstmid.rdEn", rdEn, 1'b0);
    check("rstmid.wtEn", wtEn, 1'b0);
    check("rstmid.data", dataFromMem, 16'h0);
    last_rd = 16'h0;
    reset   = 1'b0;
    rwToMem = IDEL;
    pulses  = 0;
    repeat (LAT + 2) begin
      @(posedge clk);
      #1;
      if (rdEn || wtEn) pulses++;
    end
    check("rstmid.pulse", pulses, 0);
    run_req(RD, 16'h0009, 16'h0, 16'h5555, 1'b0, 0, "rstmid.rd");

`ifdef MEM_RANGE_CHECK_EN
    run_req(WT, 16'h0105, 16'hFFFF, 16'h0, 1'b1, 0, "oob.wr");
    run_req(RD, 16'h0005, 16'h0, 16'hBEEF, 1'b0, 0, "oob.keep");
    run_req(RD, 16'h0105, 16'h0, 16'h0000, 1'b1, 0, "oob.rd");
`else
    run_req(WT, 16'h0205, 16'h1111, 16'h0, 1'b0, 0, "alias.wr");
    run_req(RD, 16'h0005, 16'h0, 16'h1111, 1'b0, 0, "alias.rd");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
